iot_riscv_trap_ctrl: RTL and testbench
======================================

Name:
iot_riscv_trap_ctrl

Overview:
- Trap sequencer for the iot_riscv machine-mode CSR set. It accepts synchronous exceptions, one external interrupt and MRET.
- It drains and flushes the pipeline, then emits the mepc/mcause/mtval write strobes toward the CSR file.
- It redirects fetch to the trap target derived from mtvec, or back to mepc on MRET.
- It owns mstatus.MIE/MPIE internally and sits between decode/execute and the CSR file and fetch.

Parameters:
- pc_size_p, 32, width of PC values.
- drain_tmo_p, 8, max cycles spent in DRAIN waiting for pipe_idle_i before proceeding anyway (>=1).

Ports:
- main_clk_i  input  1  clock.
- main_rst_an_i  input  1  async reset, low-active.
- exc_req_i  input  1  exception request, level; held by the source until exc_ack_o.
- exc_cause_i  input  4  exception code, sampled on acceptance.
- exc_tval_i  input  32  faulting address/instruction, sampled on acceptance.
- exc_pc_i  input  pc_size_p  PC of the faulting instruction.
- irq_i  input  1  external interrupt, level.
- int_pc_i  input  pc_size_p  PC of the next unretired instruction (interrupt return point).
- mret_i  input  1  MRET decoded; single-cycle pulse, honoured only in IDLE.
- pipe_idle_i  input  1  no instruction in flight past decode.
- mtvec_i  input  32  current mtvec from the CSR file.
- mepc_i  input  32  current mepc from the CSR file.
- stall_o  output  1  freeze fetch/decode.
- flush_o  output  1  kill in-flight instructions.
- exc_ack_o  output  1  one-cycle acknowledge of an accepted exception.
- trap_wr_o  output  1  one-cycle strobe: CSR file loads mepc/mcause/mtval.
- trap_mepc_o  output  32  value for mepc (zero-extended PC, bit0 forced 0).
- trap_mcause_o  output  32  value for mcause.
- trap_mtval_o  output  32  value for mtval.
- pc_load_o  output  1  one-cycle fetch redirect strobe.
- pc_target_o  output  pc_size_p  redirect target.
- mie_o  output  1  current mstatus.MIE.
- mpie_o  output  1  current mstatus.MPIE.
- busy_o  output  1  state != IDLE.

Behaviour:
- Reset values: state=IDLE; MIE=0, MPIE=1. All strobes 0; all data outputs 0.
- Priority in IDLE: exception > interrupt (irq_i & MIE) > MRET. A lower-priority event in the same cycle is dropped.
  - A dropped MRET is lost.
  - A dropped interrupt is re-evaluated because it is level.
- States: IDLE -> DRAIN -> SAVE -> JUMP -> IDLE for traps; IDLE -> JUMP -> IDLE for MRET.
- Acceptance of a trap (IDLE, 1 cycle):
  - Latch cause, tval and PC.
  - For an exception, exc_ack_o=1 in this same cycle.
  - The source drops exc_req_i the next cycle. exc_req_i seen outside IDLE is ignored.
- DRAIN:
  - stall_o=1 and flush_o=1.
  - Leaves when pipe_idle_i=1 or drain counter reaches drain_tmo_p-1, whichever is first.
  - The counter clears on entry.
- SAVE:
  - stall_o=1.
  - trap_wr_o=1 for exactly 1 cycle with the latched values.
  - mcause = {irq,27'b0,cause}; external interrupt cause=11.
  - mtval = latched tval for exceptions, 0 for interrupts.
  - MPIE<=MIE, MIE<=0.
- JUMP, trap:
  - pc_load_o=1 for 1 cycle.
  - Base = {mtvec_i[31:2],2'b00}.
  - If mtvec_i[1:0]==2'b01 and interrupt, target = base + 4*cause (mod 2^32); otherwise target = base.
  - Target is truncated to pc_size_p.
- JUMP, MRET:
  - target = {mepc_i[31:1],1'b0}.
  - MIE<=MPIE, MPIE<=1.
  - stall_o=1 in the accept cycle.
- Latency:
  - Exception accept to pc_load_o is 3 cycles when pipe_idle_i is already 1, at most drain_tmo_p+2 cycles otherwise.
  - MRET to pc_load_o is 1 cycle.
- Back-to-back: IDLE is re-entered for 1 cycle minimum before the next acceptance.
- An interrupt is never taken while MIE=0, including the cycle of an MRET that sets it.
- Reset asserted mid-sequence aborts immediately to reset values; no partial strobe completes.

Optional Feature:
- Macro: IOT_RISCV_TRAP_MTVAL_EN.
- Defined: mtval is captured and driven as above.
- Undefined:
  - exc_tval_i is ignored.
  - trap_mtval_o is constant 0 and the tval latch is not synthesized.
  - Timing is unchanged.

Test Plan:
- Reset, then exception (cause=2, tval=0xDEADBEEF, pc=0x100) with pipe_idle_i=1 and mtvec=0x200.
  - Expect exc_ack_o at cycle 0 and trap_wr_o at cycle 2 with mepc=0x100, mcause=2, mtval=0xDEADBEEF.
  - Expect pc_load_o at cycle 3 with target 0x200, then MIE=0, MPIE=0.
- MIE=1, irq_i=1, mtvec=0x301 (vectored), int_pc=0x404.
  - Expect mcause=0x8000000B, mtval=0, mepc=0x404, target 0x32C.
- Exception and irq_i (MIE=1) in the same cycle.
  - Expect the exception to be taken.
  - After return via MRET with MIE restored to 1, expect the interrupt taken next.
- pipe_idle_i held 0, drain_tmo_p=8.
  - Expect flush_o for exactly 8 cycles, then SAVE.
  - Repeat with pipe_idle_i rising after 2 cycles; expect DRAIN of 3 cycles.
- MRET with mepc=0x0000_0123 and MPIE=1.
  - Expect pc_load_o 1 cycle later with target 0x122, then MIE=1, MPIE=1.
  - MRET asserted during DRAIN is ignored.
- Assert main_rst_an_i low during DRAIN.
  - Expect state IDLE, MIE=0, MPIE=1 and no trap_wr_o/pc_load_o after release.

Source files
------------

// File: rtl/iot_riscv_trap_ctrl.sv
// Machine-mode trap sequencer: exception/interrupt entry, MRET return, MIE/MPIE ownership.
// Optional macro IOT_RISCV_TRAP_MTVAL_EN enables capture of the faulting tval into mtval.
module iot_riscv_trap_ctrl #(
  parameter int pc_size_p   = 32,
  parameter int drain_tmo_p = 8
) (
  input  logic                 main_clk_i,
  input  logic                 main_rst_an_i,
  input  logic                 exc_req_i,
  input  logic [3:0]           exc_cause_i,
  input  logic [31:0]          exc_tval_i,
  input  logic [pc_size_p-1:0] exc_pc_i,
  input  logic                 irq_i,
  input  logic [pc_size_p-1:0] int_pc_i,
  input  logic                 mret_i,
  input  logic                 pipe_idle_i,
  input  logic [31:0]          mtvec_i,
  input  logic [31:0]          mepc_i,
  output logic                 stall_o,
  output logic                 flush_o,
  output logic                 exc_ack_o,
  output logic                 trap_wr_o,
  output logic [31:0]          trap_mepc_o,
  output logic [31:0]          trap_mcause_o,
  output logic [31:0]          trap_mtval_o,
  output logic                 pc_load_o,
  output logic [pc_size_p-1:0] pc_target_o,
  output logic                 mie_o,
  output logic                 mpie_o,
  output logic                 busy_o
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_DRAIN = 2'd1;
  localparam logic [1:0] ST_SAVE  = 2'd2;
  localparam logic [1:0] ST_JUMP  = 2'd3;

  localparam int cnt_w_lp = (drain_tmo_p > 1) ? $clog2(drain_tmo_p) : 1;
  localparam logic [cnt_w_lp-1:0] cnt_last_lp = cnt_w_lp'(drain_tmo_p - 1);

  logic [1:0]           state_q, state_d;
  logic [cnt_w_lp-1:0]  cnt_q, cnt_d;
  logic                 irq_q, irq_d;
  logic                 mret_q, mret_d;
  logic [3:0]           cause_q, cause_d;
  logic [pc_size_p-1:0] pc_q, pc_d;
  logic                 mie_q, mie_d;
  logic                 mpie_q, mpie_d;
  logic                 acc_exc, acc_irq;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    irq_d     = irq_q;
    mret_d    = mret_q;
    cause_d   = cause_q;
    pc_d      = pc_q;
    mie_d     = mie_q;
    mpie_d    = mpie_q;
    acc_exc   = 1'b0;
    acc_irq   = 1'b0;
    exc_ack_o = 1'b0;
    stall_o   = 1'b0;
    flush_o   = 1'b0;
    trap_wr_o = 1'b0;
    pc_load_o = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // Fixed priority; a losing MRET pulse is simply lost.
        if (exc_req_i) begin
          acc_exc   = 1'b1;
          exc_ack_o = 1'b1;
          irq_d     = 1'b0;
          mret_d    = 1'b0;
          cause_d   = exc_cause_i;
          pc_d      = exc_pc_i;
          cnt_d     = '0;
          state_d   = ST_DRAIN;
        end else if (irq_i && mie_q) begin
          acc_irq = 1'b1;
          irq_d   = 1'b1;
          mret_d  = 1'b0;
          cause_d = 4'd11;
          pc_d    = int_pc_i;
          cnt_d   = '0;
          state_d = ST_DRAIN;
        end else if (mret_i) begin
          stall_o = 1'b1;
          mret_d  = 1'b1;
          state_d = ST_JUMP;
        end
      end
      ST_DRAIN: begin
        stall_o = 1'b1;
        flush_o = 1'b1;
        if (pipe_idle_i || (cnt_q == cnt_last_lp)) begin
          state_d = ST_SAVE;
        end else begin
          cnt_d = cnt_q + cnt_w_lp'(1);
        end
      end
      ST_SAVE: begin
        stall_o   = 1'b1;
        trap_wr_o = 1'b1;
        mpie_d    = mie_q;
        mie_d     = 1'b0;
        state_d   = ST_JUMP;
      end
      default: begin
        pc_load_o = 1'b1;
        state_d   = ST_IDLE;
        if (mret_q) begin
          mie_d  = mpie_q;
          mpie_d = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge main_clk_i or negedge main_rst_an_i) begin
    if (!main_rst_an_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      irq_q   <= 1'b0;
      mret_q  <= 1'b0;
      cause_q <= '0;
      pc_q    <= '0;
      mie_q   <= 1'b0;
      mpie_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      irq_q   <= irq_d;
      mret_q  <= mret_d;
      cause_q <= cause_d;
      pc_q    <= pc_d;
      mie_q   <= mie_d;
      mpie_q  <= mpie_d;
    end
  end

`ifdef IOT_RISCV_TRAP_MTVAL_EN
  logic [31:0] tval_q;

  always_ff @(posedge main_clk_i or negedge main_rst_an_i) begin
    if (!main_rst_an_i) begin
      tval_q <= '0;
    end else if (acc_exc) begin
      tval_q <= exc_tval_i;
    end else if (acc_irq) begin
      tval_q <= '0;
    end
  end

  assign trap_mtval_o = tval_q;
`else
  logic unused_tval;

  assign unused_tval  = ^{exc_tval_i, acc_irq};
  assign trap_mtval_o = '0;
`endif

  logic [31:0] mepc_ext;
  logic [31:0] base;
  logic [31:0] target;
  logic        unused_misc;

  always_comb begin
    mepc_ext                  = '0;
    mepc_ext[pc_size_p-1:0]   = pc_q;
    mepc_ext[0]               = 1'b0;
  end

  // Vectored mode only applies to interrupts; exceptions always land on base.
  always_comb begin
    base = {mtvec_i[31:2], 2'b00};
    if (mret_q) begin
      target = {mepc_i[31:1], 1'b0};
    end else if (irq_q && (mtvec_i[1:0] == 2'b01)) begin
      target = base + {26'b0, cause_q, 2'b00};
    end else begin
      target = base;
    end
  end

  assign unused_misc   = mepc_i[0];
  assign trap_mepc_o   = mepc_ext;
  assign trap_mcause_o = {irq_q, 27'b0, cause_q};
  assign pc_target_o   = pc_load_o ? target[pc_size_p-1:0] : '0;
  assign mie_o         = mie_q;
  assign mpie_o        = mpie_q;
  assign busy_o        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_iot_riscv_trap_ctrl.sv
// Self-checking bench for iot_riscv_trap_ctrl: directed test-plan cases plus randomized transactions
// checked against a transaction-level model of the trap/MRET rules.
module tb_iot_riscv_trap_ctrl;

  localparam int TMO = 8;

  logic        main_clk_i = 1'b0;
  logic        main_rst_an_i;
  logic        exc_req_i;
  logic [3:0]  exc_cause_i;
  logic [31:0] exc_tval_i;
  logic [31:0] exc_pc_i;
  logic        irq_i;
  logic [31:0] int_pc_i;
  logic        mret_i;
  logic        pipe_idle_i;
  logic [31:0] mtvec_i;
  logic [31:0] mepc_i;
  logic        stall_o, flush_o, exc_ack_o, trap_wr_o, pc_load_o;
  logic [31:0] trap_mepc_o, trap_mcause_o, trap_mtval_o, pc_target_o;
  logic        mie_o, mpie_o, busy_o;

  int checks = 0;
  int errors = 0;
  int txn_no = 0;
  bit mie_m  = 1'b0;
  bit mpie_m = 1'b1;

  iot_riscv_trap_ctrl #(.pc_size_p(32), .drain_tmo_p(TMO)) dut (
    .main_clk_i(main_clk_i), .main_rst_an_i(main_rst_an_i),
    .exc_req_i(exc_req_i), .exc_cause_i(exc_cause_i), .exc_tval_i(exc_tval_i),
    .exc_pc_i(exc_pc_i), .irq_i(irq_i), .int_pc_i(int_pc_i), .mret_i(mret_i),
    .pipe_idle_i(pipe_idle_i), .mtvec_i(mtvec_i), .mepc_i(mepc_i),
    .stall_o(stall_o), .flush_o(flush_o), .exc_ack_o(exc_ack_o), .trap_wr_o(trap_wr_o),
    .trap_mepc_o(trap_mepc_o), .trap_mcause_o(trap_mcause_o), .trap_mtval_o(trap_mtval_o),
    .pc_load_o(pc_load_o), .pc_target_o(pc_target_o), .mie_o(mie_o), .mpie_o(mpie_o),
    .busy_o(busy_o)
  );

  always #5 main_clk_i = ~main_clk_i;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // One IDLE-cycle request followed by the whole resulting sequence.
  // d: pipe_idle_i rises on the d-th DRAIN cycle (0 = already idle).
  task automatic do_txn(input bit e, input bit i, input bit m, input logic [3:0] cause,
                        input logic [31:0] tval, input logic [31:0] pc, input logic [31:0] ipc,
                        input logic [31:0] mtvec, input logic [31:0] mepc, input int d,
                        input bit mret_in_drain);
    bit is_exc, is_irq, is_mret, is_trap;
    int drain_len, flush_cnt, wr_cnt, wr_k, ld_k;
    logic [31:0] exp_mcause, exp_mtval, exp_mepc, exp_tgt, base;
    is_exc  = e;
    is_irq  = !e && i && mie_m;
    is_mret = !e && !is_irq && m;
    is_trap = is_exc || is_irq;
    drain_len = (d + 1 < TMO) ? d + 1 : TMO;
    base       = mtvec & 32'hFFFF_FFFC;
    exp_mcause = is_irq ? 32'h8000_000B : {28'h0, cause};
`ifdef IOT_RISCV_TRAP_MTVAL_EN
    exp_mtval  = is_irq ? 32'h0 : tval;
`else
    exp_mtval  = 32'h0;
`endif
    exp_mepc   = (is_irq ? ipc : pc) & 32'hFFFF_FFFE;
    if (is_mret)                              exp_tgt = mepc & 32'hFFFF_FFFE;
    else if (is_irq && (mtvec % 4 == 1))      exp_tgt = base + 4 * 11;
    else                                      exp_tgt = base;

    @(posedge main_clk_i); #1;
    exc_req_i = e; exc_cause_i = cause; exc_tval_i = tval; exc_pc_i = pc;
    irq_i = i; int_pc_i = ipc; mret_i = m; mtvec_i = mtvec; mepc_i = mepc;
    pipe_idle_i = (d == 0);
    @(negedge main_clk_i);
    check_val("busy_c0", busy_o, 0);
    check_val("ack_c0", exc_ack_o, e);
    check_val("mie_c0", mie_o, mie_m);
    check_val("mpie_c0", mpie_o, mpie_m);
    if (is_mret) check_val("mret_stall", stall_o, 1);

    flush_cnt = 0; wr_cnt = 0; wr_k = -1; ld_k = -1;
    for (int k = 1; k <= 20; k++) begin
      @(posedge main_clk_i); #1;
      exc_req_i = 1'b0; irq_i = 1'b0;
      mret_i = mret_in_drain && is_trap && (k == 2);
      exc_cause_i = 4'($urandom); exc_tval_i = $urandom; exc_pc_i = $urandom; int_pc_i = $urandom;
      pipe_idle_i = ((k - 1) >= d);
      @(negedge main_clk_i);
      if (!is_trap && !is_mret) begin
        check_val("idle_stays", busy_o, 0);
        break;
      end
      if (flush_o) begin
        flush_cnt++;
        check_val("drain_stall", stall_o, 1);
      end
      if (trap_wr_o) begin
        wr_cnt++;
        wr_k = k;
        check_val("save_stall", stall_o, 1);
        check_val("mepc", trap_mepc_o, exp_mepc);
        check_val("mcause", trap_mcause_o, exp_mcause);
        check_val("mtval", trap_mtval_o, exp_mtval);
      end
      if (pc_load_o) begin
        ld_k = k;
        check_val("target", pc_target_o, exp_tgt);
        break;
      end
    end
    mret_i = 1'b0;

    if (is_trap) begin
      check_val("flush_cycles", flush_cnt, drain_len);
      check_val("wr_count", wr_cnt, 1);
      check_val("wr_cycle", wr_k, drain_len + 1);
      check_val("ld_cycle", ld_k, drain_len + 2);
      mpie_m = mie_m;
      mie_m  = 1'b0;
    end else if (is_mret) begin
      check_val("mret_flush", flush_cnt, 0);
      check_val("mret_wr", wr_cnt, 0);
      check_val("mret_ld_cycle", ld_k, 1);
      mie_m  = mpie_m;
      mpie_m = 1'b1;
    end
    txn_no++;
    $display("txn %0d: kind=%s cause=%0d drain=%0d target=0x%08h mie=%0d mpie=%0d checks=%0d errors=%0d",
             txn_no, is_exc ? "exc" : is_irq ? "irq" : is_mret ? "mret" : "none",
             is_irq ? 11 : cause, is_trap ? drain_len : 0, exp_tgt, mie_m, mpie_m, checks, errors);
  endtask

  initial begin
    bit seen_strobe;
    main_rst_an_i = 1'b0;
    exc_req_i = 0; exc_cause_i = 0; exc_tval_i = 0; exc_pc_i = 0; irq_i = 0; int_pc_i = 0;
    mret_i = 0; pipe_idle_i = 0; mtvec_i = 0; mepc_i = 0;
    repeat (3) @(posedge main_clk_i);
    #1 main_rst_an_i = 1'b1;
    @(negedge main_clk_i);
    check_val("rst_busy", busy_o, 0);
    check_val("rst_mie", mie_o, 0);
    check_val("rst_mpie", mpie_o, 1);
    check_val("rst_strobes", {stall_o, flush_o, exc_ack_o, trap_wr_o, pc_load_o}, 0);
    check_val("rst_mepc", trap_mepc_o, 0);
    check_val("rst_mcause", trap_mcause_o, 0);
    check_val("rst_mtval", trap_mtval_o, 0);
    check_val("rst_target", pc_target_o, 0);

    // Basic exception, non-vectored target.
    do_txn(1, 0, 0, 4'd2, 32'hDEADBEEF, 32'h100, 32'h0, 32'h200, 32'h0, 0, 0);
    do_txn(0, 0, 1, 4'd0, 0, 0, 0, 32'h200, 32'h0000_0124, 0, 0);
    // MRET to odd mepc with MPIE=1 -> MIE=1.
    do_txn(0, 0, 1, 4'd0, 0, 0, 0, 32'h200, 32'h0000_0123, 0, 0);
    // Vectored external interrupt.
    do_txn(0, 1, 0, 4'd0, 0, 0, 32'h404, 32'h301, 32'h0, 0, 0);
    do_txn(0, 0, 1, 4'd0, 0, 0, 0, 32'h301, 32'h404, 0, 0);
    // Exception beats interrupt; interrupt taken after MRET restores MIE.
    do_txn(1, 1, 0, 4'd7, 32'h55AA, 32'h800, 32'h900, 32'h301, 32'h0, 0, 0);
    do_txn(0, 0, 1, 4'd0, 0, 0, 0, 32'h301, 32'h800, 0, 0);
    do_txn(0, 1, 1, 4'd0, 0, 0, 32'h904, 32'h301, 32'h800, 0, 0);
    // Drain timeout, then early pipe_idle, with an MRET pulse during DRAIN.
    do_txn(1, 0, 0, 4'd4, 32'h1234, 32'hA00, 0, 32'h1000, 32'h0, 30, 1);
    do_txn(1, 0, 0, 4'd5, 32'h5678, 32'hB00, 0, 32'h1000, 32'h0, 2, 1);

    // Reset in the middle of DRAIN.
    @(posedge main_clk_i); #1;
    exc_req_i = 1; exc_cause_i = 4'd3; exc_pc_i = 32'hC00; pipe_idle_i = 0;
    @(posedge main_clk_i); #1;
    exc_req_i = 0;
    @(posedge main_clk_i); #1;
    main_rst_an_i = 1'b0;
    #1;
    check_val("midrst_busy", busy_o, 0);
    check_val("midrst_mie", mie_o, 0);
    check_val("midrst_mpie", mpie_o, 1);
    check_val("midrst_strobes", {flush_o, trap_wr_o, pc_load_o}, 0);
    @(posedge main_clk_i); #1;
    main_rst_an_i = 1'b1;
    mie_m = 1'b0; mpie_m = 1'b1;
    seen_strobe = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge main_clk_i);
      if (trap_wr_o || pc_load_o || busy_o) seen_strobe = 1;
    end
    check_val("postrst_quiet", seen_strobe, 0);

    // Randomized transactions against the model.
    for (int n = 0; n < 60; n++) begin
      bit e, i, m, mid;
      logic [31:0] mt;
      e   = ($urandom_range(0, 2) == 0);
      i   = 1'($urandom_range(0, 1));
      m   = 1'($urandom_range(0, 1));
      mid = 1'($urandom_range(0, 1));
      mt  = ($urandom & 32'hFFFF_FFFC) | ($urandom_range(0, 1) ? 32'd1 : 32'($urandom_range(0, 3)));
      do_txn(e, i, m, 4'($urandom), $urandom, $urandom, $urandom, mt, $urandom,
             $urandom_range(0, 11), mid);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
